// File: rtl/shiftrdesern_pkg.sv
// rtl/shiftrdesern_pkg.sv - shared state encodings and default word width for shiftrdesern
package shiftrdesern_pkg;

  localparam int WORD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } state_t;

endpackage

// File: rtl/shiftrdesern_bit_cnt.sv
// rtl/shiftrdesern_bit_cnt.sv - frame bit counter with clear, load-1, increment and terminal count
module shiftrdesern_bit_cnt #(
  parameter int N = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load1,
  input  logic inc,
  output logic tc,
  output logic last
);

  localparam int CW = $clog2(N + 1);

  logic [CW-1:0] cnt;

  // load1 wins over clr so a start on the edge after a frame is never lost
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= CW'(1);
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tc   = (cnt == CW'(N));
  assign last = (cnt == CW'(N - 1));

endmodule

// File: rtl/shiftrdesern.sv
// rtl/shiftrdesern.sv - N-bit serial-to-parallel receiver, MSB first, valid/ready output buffer
// Define PARITY_CHECK_EN to add a trailing even-parity bit per frame and the perr output.
module shiftrdesern
  import shiftrdesern_pkg::*;
#(
  parameter int N = WORD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         start,
  input  logic         SI,
  output logic [N-1:0] q,
  output logic         valid,
  input  logic         ready,
  output logic         ovf
`ifdef PARITY_CHECK_EN
  ,
  output logic         perr
`endif
);

  state_t        state_q, state_d;
  logic [N-1:0]  sr;
  logic [N-1:0]  word;
  logic          shift, cnt_load1, cnt_inc, cnt_clr;
  logic          cnt_tc, cnt_last;
  logic          deliver, accept;

  shiftrdesern_bit_cnt #(.N(N)) u_bit_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .load1 (cnt_load1),
    .inc   (cnt_inc),
    .tc    (cnt_tc),
    .last  (cnt_last)
  );

`ifdef PARITY_CHECK_EN
  logic par_bad;
  assign word    = sr;
  assign par_bad = ^{sr, SI};
`else
  // The completing bit is still on SI, so the word is formed from the next sr value
  assign word = {sr[N-2:0], SI};
`endif

  always_comb begin
    state_d   = state_q;
    shift     = 1'b0;
    cnt_load1 = 1'b0;
    cnt_inc   = 1'b0;
    deliver   = 1'b0;
    cnt_clr   = (state_q == ST_IDLE) && cnt_tc;
    case (state_q)
      ST_IDLE: begin
        if (en && start) begin
          shift     = 1'b1;
          cnt_load1 = 1'b1;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (en) begin
          shift = 1'b1;
          if (start) begin
            cnt_load1 = 1'b1;
          end else begin
            cnt_inc = 1'b1;
            if (cnt_last) begin
`ifdef PARITY_CHECK_EN
              state_d = ST_PAR;
`else
              deliver = 1'b1;
              state_d = ST_IDLE;
`endif
            end
          end
        end
      end
`ifdef PARITY_CHECK_EN
      ST_PAR: begin
        if (en) begin
          deliver = 1'b1;
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept = deliver && (!valid || ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      sr      <= '0;
    end else begin
      state_q <= state_d;
      if (shift) begin
        sr <= {sr[N-2:0], SI};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q     <= '0;
      valid <= 1'b0;
      ovf   <= 1'b0;
    end else if (deliver) begin
      if (accept) begin
        q     <= word;
        valid <= 1'b1;
      end else begin
        ovf <= 1'b1;
      end
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

`ifdef PARITY_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perr <= 1'b0;
    end else if (accept) begin
      perr <= par_bad;
    end
  end
`endif

endmodule

// File: tb/tb_shiftrdesern.sv
// tb/tb_shiftrdesern.sv - self-checking bench for shiftrdesern (directed plus random stimulus)
// Parity cases are exercised when PARITY_CHECK_EN is defined.
module tb_shiftrdesern;

  localparam int N = 8;
`ifdef PARITY_CHECK_EN
  localparam int FRAME = N + 1;
`else
  localparam int FRAME = N;
`endif

  logic         clk, rst, en, start, SI, ready;
  logic [N-1:0] q;
  logic         valid, ovf;
`ifdef PARITY_CHECK_EN
  logic         perr;
`endif

  int total = 0;
  int bad   = 0;

  shiftrdesern #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .start (start),
    .SI    (SI),
    .q     (q),
    .valid (valid),
    .ready (ready),
    .ovf   (ovf)
`ifdef PARITY_CHECK_EN
    ,
    .perr  (perr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: collected frame bits in a queue, word assembled arithmetically on completion
  int           bits[$];
  bit           in_frame;
  logic [N-1:0] m_q;
  bit           m_valid, m_ovf, m_perr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    bits.delete();
    in_frame = 0;
    m_q = '0; m_valid = 0; m_ovf = 0; m_perr = 0;
  endtask

  task automatic model_edge(input bit e, input bit s, input bit d, input bit r);
    bit           dlv;
    logic [N-1:0] w;
    bit           p;
    dlv = 0; w = '0; p = 0;
    if (e) begin
      if (s && !(in_frame && bits.size() == N)) begin
        bits.delete();
        bits.push_back(int'(d));
        in_frame = 1;
      end else if (in_frame) begin
        bits.push_back(int'(d));
      end
      if (in_frame && bits.size() == FRAME) begin
        for (int i = 0; i < N; i++) w = N'(w * 2 + bits[i]);
        foreach (bits[i]) p ^= bits[i][0];
        dlv = 1;
        in_frame = 0;
        bits.delete();
      end
    end
    if (dlv) begin
      if (!m_valid || r) begin
        m_q = w; m_valid = 1; m_perr = p;
      end else begin
        m_ovf = 1;
      end
    end else if (m_valid && r) begin
      m_valid = 0;
    end
  endtask

  task automatic compare_all();
    chk("q", 32'(q), 32'(m_q));
    chk("valid", 32'(valid), 32'(m_valid));
    chk("ovf", 32'(ovf), 32'(m_ovf));
`ifdef PARITY_CHECK_EN
    chk("perr", 32'(perr), 32'(m_perr));
`endif
  endtask

  task automatic step(input bit e, input bit s, input bit d, input bit r);
    en = e; start = s; SI = d; ready = r;
    @(posedge clk);
    model_edge(e, s, d, r);
    #1;
    compare_all();
  endtask

  task automatic send_word(input logic [N-1:0] w, input int gap, input bit r);
    for (int i = N - 1; i >= 0; i--) begin
      step(1'b1, i == N - 1, w[i], r);
      if (i != 0) repeat (gap) step(1'b0, 1'b0, 1'b0, r);
    end
  endtask

  task automatic do_reset();
    en = 0; start = 0; SI = 0;
    #2 rst = 1'b0;
    #1 model_reset();
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    logic [N-1:0] partial;
    rst = 1'b0; en = 0; start = 0; SI = 0; ready = 0;
    model_reset();
    do_reset();

    // basic receive
    send_word(8'hA5, 0, 1'b1);
    chk("basic_q", 32'(q), 32'hA5);
    chk("basic_valid", 32'(valid), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("basic_drop", 32'(valid), 32'd0);

    // en gaps between bits
    send_word(8'h3C, 3, 1'b1);
    chk("gap_q", 32'(q), 32'h3C);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // overrun
    send_word(8'h11, 0, 1'b0);
    send_word(8'h22, 0, 1'b0);
    chk("ovr_q", 32'(q), 32'h11);
    chk("ovr_ovf", 32'(ovf), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_clear", 32'(valid), 32'd0);
    chk("ovr_sticky", 32'(ovf), 32'd1);

    // same-edge consume and deliver
    do_reset();
    send_word(8'h11, 0, 1'b0);
    for (int i = N - 1; i >= 0; i--) step(1'b1, i == N - 1, partial_bit(8'h99, i), i == 0);
    chk("same_q", 32'(q), 32'h99);
    chk("same_valid", 32'(valid), 32'd1);
    chk("same_ovf", 32'(ovf), 32'd0);

    // restart mid-frame
    partial = 8'hFF;
    for (int i = 0; i < 5; i++) step(1'b1, i == 0, partial[i], 1'b1);
    send_word(8'hC3, 0, 1'b1);
    chk("restart_q", 32'(q), 32'hC3);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // reset mid-frame, then bits without start are ignored
    for (int i = 0; i < 4; i++) step(1'b1, i == 0, 1'b1, 1'b1);
    do_reset();
    for (int i = 0; i < N; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("no_start_valid", 32'(valid), 32'd0);
    chk("no_start_q", 32'(q), 32'd0);

`ifdef PARITY_CHECK_EN
    send_word(8'h07, 0, 1'b1);
    chk("par_wait", 32'(valid), 32'd0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("par_ok_valid", 32'(valid), 32'd1);
    chk("par_ok_perr", 32'(perr), 32'd0);
    send_word(8'h07, 0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("par_bad_q", 32'(q), 32'h07);
    chk("par_bad_perr", 32'(perr), 32'd1);
`endif

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
           1'($urandom), $urandom_range(0, 9) < 6);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic bit partial_bit(input logic [N-1:0] w, input int i);
    return w[i];
  endfunction

endmodule
